// File: rtl/i3c_sdr_bus_monitor.sv
// Passive I3C SDR bus monitor. It synchronizes and deglitches SCL/SDA,
// detects START / Repeated START / STOP, and deserializes 9-bit frames
// (8 data bits MSB-first plus ACK/T-bit) into bytes and bus events.
module i3c_sdr_bus_monitor #(
    parameter int unsigned FILT_CYCLES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             start_o,
    output logic             rstart_o,
    output logic             stop_o,
    output logic             byte_valid_o,
    output logic [7:0]       byte_o,
    output logic             ninth_o,
    output logic             addr_o,
    output logic             frame_err_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] byte_cnt_o
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    localparam logic [3:0] FILT_LIM = 4'(FILT_CYCLES);

    // index 0 = SCL, index 1 = SDA
    logic [1:0] pins;
    logic [1:0] sync1, sync2, filt, filt_q;

    assign pins = {sda_i, scl_i};

    for (genvar g = 0; g < 2; g++) begin : g_line
        logic [3:0] fcnt;

        // Two-flop synchronizer, then a filter that flips only after the
        // synchronized value has disagreed for FILT_CYCLES consecutive clocks.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sync1[g]  <= 1'b1;
                sync2[g]  <= 1'b1;
                filt[g]   <= 1'b1;
                filt_q[g] <= 1'b1;
                fcnt      <= '0;
            end else begin
                sync1[g]  <= pins[g];
                sync2[g]  <= sync1[g];
                filt_q[g] <= filt[g];
                if (sync2[g] != filt[g]) begin
                    if (fcnt + 4'd1 == FILT_LIM) begin
                        filt[g] <= sync2[g];
                        fcnt    <= '0;
                    end else begin
                        fcnt <= fcnt + 4'd1;
                    end
                end else begin
                    fcnt <= '0;
                end
            end
        end
    end

    logic scl_f, scl_q, sda_f, sda_q;
    logic scl_rise, scl_fall, start_cond, stop_cond;

    assign scl_f      = filt[0];
    assign scl_q      = filt_q[0];
    assign sda_f      = filt[1];
    assign sda_q      = filt_q[1];
    assign scl_rise   = scl_f & ~scl_q;
    assign scl_fall   = ~scl_f & scl_q;
    assign start_cond = scl_q & scl_f & sda_q & ~sda_f;
    assign stop_cond  = scl_q & scl_f & ~sda_q & sda_f;

    state_e           state, state_n;
    logic [3:0]       bit_cnt, bit_cnt_n;
    logic [3:0]       bits_done, bits_done_n;
    logic [7:0]       shift, shift_n;
    logic [7:0]       byte_n;
    logic             ninth_n, addr_n, busy_n;
    logic             start_n, rstart_n, stop_n, bv_n, ferr_n;
    logic [CNT_W-1:0] cnt_n;

    // Next-state and next-output decode of the frame state machine.
    // bits_done is bit_cnt as of the last SCL fall: the SCL rise that sets
    // up an Sr or STOP shifts a bit but is not part of the frame, so frame
    // errors are judged on completed (fallen) bits only.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        bits_done_n = bits_done;
        shift_n     = shift;
        byte_n      = byte_o;
        ninth_n     = ninth_o;
        addr_n      = addr_o;
        cnt_n       = byte_cnt_o;
        start_n     = 1'b0;
        rstart_n    = 1'b0;
        stop_n      = 1'b0;
        bv_n        = 1'b0;
        ferr_n      = 1'b0;
        if (!enable_i) begin
            state_n     = IDLE;
            bit_cnt_n   = '0;
            bits_done_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_cond) begin
                        state_n     = ADDR;
                        start_n     = 1'b1;
                        bit_cnt_n   = '0;
                        bits_done_n = '0;
                        cnt_n       = '0;
                    end else if (stop_cond) begin
                        stop_n = 1'b1;
                    end
                end
                default: begin
                    if (start_cond) begin
                        rstart_n    = 1'b1;
                        ferr_n      = (bits_done != 4'd0);
                        state_n     = ADDR;
                        bit_cnt_n   = '0;
                        bits_done_n = '0;
                        cnt_n       = '0;
                    end else if (stop_cond) begin
                        stop_n      = 1'b1;
                        ferr_n      = (bits_done != 4'd0);
                        state_n     = IDLE;
                        bit_cnt_n   = '0;
                        bits_done_n = '0;
                    end else if (scl_rise) begin
                        if (bit_cnt == 4'd8) begin
                            bv_n      = 1'b1;
                            byte_n    = shift;
                            ninth_n   = sda_f;
                            addr_n    = (state == ADDR);
                            bit_cnt_n = '0;
                            state_n   = DATA;
                            if (byte_cnt_o != '1) cnt_n = byte_cnt_o + CNT_W'(1);
                        end else begin
                            shift_n   = {shift[6:0], sda_f};
                            bit_cnt_n = bit_cnt + 4'd1;
                        end
                    end else if (scl_fall) begin
                        bits_done_n = bit_cnt;
                    end
                end
            endcase
        end
        busy_n = (state_n != IDLE);
    end

    // State, frame counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            bits_done    <= '0;
            shift        <= '0;
            byte_o       <= '0;
            ninth_o      <= 1'b0;
            addr_o       <= 1'b0;
            byte_cnt_o   <= '0;
            busy_o       <= 1'b0;
            start_o      <= 1'b0;
            rstart_o     <= 1'b0;
            stop_o       <= 1'b0;
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            state        <= state_n;
            bit_cnt      <= bit_cnt_n;
            bits_done    <= bits_done_n;
            shift        <= shift_n;
            byte_o       <= byte_n;
            ninth_o      <= ninth_n;
            addr_o       <= addr_n;
            byte_cnt_o   <= cnt_n;
            busy_o       <= busy_n;
            start_o      <= start_n;
            rstart_o     <= rstart_n;
            stop_o       <= stop_n;
            byte_valid_o <= bv_n;
            frame_err_o  <= ferr_n;
        end
    end

endmodule

// File: tb/tb_i3c_sdr_bus_monitor.sv
// Self-checking bench for i3c_sdr_bus_monitor: a bit-banged I3C SDR bus
// driver, a queue of expected events, and a monitor comparing every pulse.
module tb_i3c_sdr_bus_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b1;
    logic       scl = 1'b1;
    logic       sda = 1'b1;
    logic       start_o, rstart_o, stop_o, byte_valid_o, ninth_o, addr_o;
    logic       frame_err_o, busy_o;
    logic [7:0] byte_o;
    logic [7:0] byte_cnt_o;

    int vectors = 0;
    int miscompares = 0;
    int H = 8;

    i3c_sdr_bus_monitor #(.FILT_CYCLES(2), .CNT_W(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (enable),
        .scl_i        (scl),
        .sda_i        (sda),
        .start_o      (start_o),
        .rstart_o     (rstart_o),
        .stop_o       (stop_o),
        .byte_valid_o (byte_valid_o),
        .byte_o       (byte_o),
        .ninth_o      (ninth_o),
        .addr_o       (addr_o),
        .frame_err_o  (frame_err_o),
        .busy_o       (busy_o),
        .byte_cnt_o   (byte_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       s;
        logic       r;
        logic       p;
        logic       fe;
        logic       bv;
        logic [7:0] data;
        logic       ninth;
        logic       addr;
        logic [7:0] cnt;
    } ev_t;

    function automatic ev_t ev(input logic s, input logic r, input logic p,
                               input logic fe, input logic bv,
                               input logic [7:0] d, input logic n,
                               input logic a, input logic [7:0] c);
        ev_t e;
        e = '{s: s, r: r, p: p, fe: fe, bv: bv, data: d, ninth: n, addr: a, cnt: c};
        return e;
    endfunction

    ev_t   expq[$];
    string nameq[$];
    ev_t   obs_ev, exp_ev;
    string exp_name;

    task automatic expect_ev(input string n, input ev_t e);
        expq.push_back(e);
        nameq.push_back(n);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic drained(input string name);
        check(name, 32'(expq.size()), 32'd0);
        expq.delete();
        nameq.delete();
    endtask

    // Every cycle carrying a pulse is one observed event, matched in order.
    always @(negedge clk) begin
        if (rst_n && (start_o | rstart_o | stop_o | byte_valid_o | frame_err_o)) begin
            obs_ev = ev(start_o, rstart_o, stop_o, frame_err_o, byte_valid_o,
                        byte_valid_o ? byte_o : 8'h00,
                        byte_valid_o ? ninth_o : 1'b0,
                        byte_valid_o ? addr_o : 1'b0, byte_cnt_o);
            vectors++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event got=%h required=none", obs_ev);
            end else begin
                exp_ev   = expq.pop_front();
                exp_name = nameq.pop_front();
                if (obs_ev !== exp_ev) begin
                    miscompares++;
                    $display("FAIL %s got=%h required=%h", exp_name, obs_ev, exp_ev);
                end
            end
        end
    end

    // Bus driver: each level is held H clocks, well past the filter latency.
    task automatic drive(input logic c, input logic d);
        scl = c;
        sda = d;
        repeat (H) @(posedge clk);
        #2;
    endtask

    task automatic bus_start();
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
    endtask

    task automatic bus_rstart();
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
    endtask

    task automatic bus_stop();
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
    endtask

    task automatic bus_bit(input logic b);
        drive(1'b0, b);
        drive(1'b1, b);
        drive(1'b0, b);
    endtask

    task automatic bus_bits(input logic [7:0] d, input int n);
        for (int i = 7; i > 7 - n; i--) bus_bit(d[i]);
    endtask

    task automatic bus_byte(input logic [7:0] d, input logic n);
        bus_bits(d, 8);
        bus_bit(n);
    endtask

    // SDA changes on the same pin edge as SCL.
    task automatic bus_byte_simul(input logic [7:0] d, input logic n);
        for (int i = 7; i >= 0; i--) begin
            drive(1'b1, d[i]);
            drive(1'b0, d[i]);
        end
        drive(1'b1, n);
        drive(1'b0, n);
    endtask

    typedef enum {OP_START, OP_RSTART, OP_STOP, OP_BYTE, OP_BITS} op_e;

    typedef struct {
        string      name;
        op_e        op;
        logic [7:0] data;
        logic       ninth;
        int         nbits;
        bit         has_exp;
        ev_t        exp;
        logic       busy;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mkv(input string n, input op_e op, input logic [7:0] d,
                                 input logic nin, input int nb, input bit he,
                                 input ev_t e, input logic b);
        vec_t v;
        v.name = n; v.op = op; v.data = d; v.ninth = nin; v.nbits = nb;
        v.has_exp = he; v.exp = e; v.busy = b;
        return v;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1);
    end

    initial begin
        // private write, repeated START, mid-frame abort
        vecs[0]  = mkv("pw_start",  OP_START,  8'h00, 1'b0, 0, 1, ev(1,0,0,0,0,8'h00,0,0,8'd0), 1'b1);
        vecs[1]  = mkv("pw_addr",   OP_BYTE,   8'hB4, 1'b0, 0, 1, ev(0,0,0,0,1,8'hB4,0,1,8'd1), 1'b1);
        vecs[2]  = mkv("pw_data",   OP_BYTE,   8'hA5, 1'b1, 0, 1, ev(0,0,0,0,1,8'hA5,1,0,8'd2), 1'b1);
        vecs[3]  = mkv("pw_stop",   OP_STOP,   8'h00, 1'b0, 0, 1, ev(0,0,1,0,0,8'h00,0,0,8'd2), 1'b0);
        vecs[4]  = mkv("sr_start",  OP_START,  8'h00, 1'b0, 0, 1, ev(1,0,0,0,0,8'h00,0,0,8'd0), 1'b1);
        vecs[5]  = mkv("sr_bcast",  OP_BYTE,   8'hFC, 1'b0, 0, 1, ev(0,0,0,0,1,8'hFC,0,1,8'd1), 1'b1);
        vecs[6]  = mkv("sr_rstart", OP_RSTART, 8'h00, 1'b0, 0, 1, ev(0,1,0,0,0,8'h00,0,0,8'd0), 1'b1);
        vecs[7]  = mkv("sr_addr2",  OP_BYTE,   8'h11, 1'b0, 0, 1, ev(0,0,0,0,1,8'h11,0,1,8'd1), 1'b1);
        vecs[8]  = mkv("sr_stop",   OP_STOP,   8'h00, 1'b0, 0, 1, ev(0,0,1,0,0,8'h00,0,0,8'd1), 1'b0);
        vecs[9]  = mkv("ab_start",  OP_START,  8'h00, 1'b0, 0, 1, ev(1,0,0,0,0,8'h00,0,0,8'd0), 1'b1);
        vecs[10] = mkv("ab_bits",   OP_BITS,   8'hA0, 1'b0, 4, 0, ev(0,0,0,0,0,8'h00,0,0,8'd0), 1'b1);
        vecs[11] = mkv("ab_stop",   OP_STOP,   8'h00, 1'b0, 0, 1, ev(0,0,1,1,0,8'h00,0,0,8'd0), 1'b0);

        // reset values
        #1 rst_n = 1'b0;
        #2;
        check("reset_outputs",
              32'({start_o, rstart_o, stop_o, byte_valid_o, frame_err_o, busy_o,
                   ninth_o, addr_o, byte_o, byte_cnt_o}), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        drained("reset_release_quiet");

        // filter: 1-clock glitch rejected, 3-clock glitch is START then STOP
        sda = 1'b0;
        @(posedge clk);
        #2 sda = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        drained("glitch1_no_start");
        check("glitch1_busy", 32'(busy_o), 32'd0);
        expect_ev("glitch3_start", ev(1,0,0,0,0,8'h00,0,0,8'd0));
        expect_ev("glitch3_stop",  ev(0,0,1,0,0,8'h00,0,0,8'd0));
        sda = 1'b0;
        repeat (3) @(posedge clk);
        #2 sda = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        drained("glitch3_events");

        // table-driven transactions
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].has_exp) expect_ev(vecs[i].name, vecs[i].exp);
            case (vecs[i].op)
                OP_START:  bus_start();
                OP_RSTART: bus_rstart();
                OP_STOP:   bus_stop();
                OP_BYTE:   bus_byte(vecs[i].data, vecs[i].ninth);
                default:   bus_bits(vecs[i].data, vecs[i].nbits);
            endcase
            drained({vecs[i].name, "_drained"});
            check({vecs[i].name, "_busy"}, 32'(busy_o), 32'(vecs[i].busy));
        end
        check("byte_hold", 32'({byte_o, ninth_o, addr_o}), 32'({8'h11, 1'b0, 1'b1}));

        // simultaneous SCL/SDA edges
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b1);
        drained("simul_idle_no_event");
        expect_ev("simul_start", ev(1,0,0,0,0,8'h00,0,0,8'd0));
        expect_ev("simul_byte",  ev(0,0,0,0,1,8'h5A,1,1,8'd1));
        expect_ev("simul_stop",  ev(0,0,1,0,0,8'h00,0,0,8'd1));
        bus_start();
        bus_byte_simul(8'h5A, 1'b1);
        bus_stop();
        drained("simul_events");

        // reset mid-byte
        expect_ev("rst_start", ev(1,0,0,0,0,8'h00,0,0,8'd0));
        bus_start();
        bus_bits(8'hF0, 4);
        drive(1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs",
              32'({start_o, rstart_o, stop_o, byte_valid_o, frame_err_o, busy_o,
                   ninth_o, addr_o, byte_o, byte_cnt_o}), 32'd0);
        scl = 1'b1;
        sda = 1'b1;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        drained("midreset_quiet");

        // enable dropped mid-byte, byte without START is ignored
        expect_ev("en_start", ev(1,0,0,0,0,8'h00,0,0,8'd0));
        bus_start();
        bus_bits(8'hA0, 4);
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("en_off_busy", 32'(busy_o), 32'd0);
        enable = 1'b1;
        bus_byte(8'h3C, 1'b0);
        drained("en_no_byte");
        check("en_reenabled_busy", 32'(busy_o), 32'd0);
        expect_ev("en_idle_stop", ev(0,0,1,0,0,8'h00,0,0,8'd0));
        bus_stop();
        drained("en_idle_stop_drained");
        expect_ev("en2_start", ev(1,0,0,0,0,8'h00,0,0,8'd0));
        expect_ev("en2_byte",  ev(0,0,0,0,1,8'h3C,0,1,8'd1));
        expect_ev("en2_stop",  ev(0,0,1,0,0,8'h00,0,0,8'd1));
        bus_start();
        bus_byte(8'h3C, 1'b0);
        bus_stop();
        drained("en2_events");

        // byte counter saturation
        H = 6;
        expect_ev("sat_start", ev(1,0,0,0,0,8'h00,0,0,8'd0));
        bus_start();
        for (int i = 0; i < 256; i++) begin
            expect_ev("sat_byte", ev(0,0,0,0,1,8'(i),0,(i == 0),(i >= 254) ? 8'd255 : 8'(i + 1)));
            bus_byte(8'(i), 1'b0);
        end
        expect_ev("sat_stop", ev(0,0,1,0,0,8'h00,0,0,8'd255));
        bus_stop();
        drained("sat_events");
        H = 8;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i3c_sdr_bus_monitor.md
Name: i3c_sdr_bus_monitor

Overview:
- Passive SDR-mode decoder on the I3C bus; sits directly downstream of the bus-model interface and consumes the resolved wired-AND SCL/SDA lines.
- Synchronizes and deglitches both lines, then detects START, Repeated START and STOP.
- Deserializes each 9-bit frame (8 data bits MSB-first plus the ACK/T-bit) and emits decoded bytes and bus events to scoreboards and checkers on a single system clock.

Parameters:
- FILT_CYCLES, 2: consecutive clocks a synchronized line must differ from its filtered value before the filtered value changes; legal range 1..15.
- CNT_W, 8: width of the per-transaction byte counter.

Ports:
- clk_i  input  1  system clock; all logic on its rising edge
- rst_ni  input  1  asynchronous active-low reset
- enable_i  input  1  decoder enable
- scl_i  input  1  resolved SCL line
- sda_i  input  1  resolved SDA line (lane 0)
- start_o  output  1  1-cycle pulse: START from idle
- rstart_o  output  1  1-cycle pulse: Repeated START
- stop_o  output  1  1-cycle pulse: STOP
- byte_valid_o  output  1  1-cycle pulse: byte_o, ninth_o and addr_o are valid
- byte_o  output  8  decoded byte, MSB first on the wire
- ninth_o  output  1  9th bit (ACK = 0 / T-bit)
- addr_o  output  1  byte is the first byte after (R)START, i.e. address plus RnW
- frame_err_o  output  1  1-cycle pulse: (R)START or STOP seen mid-frame
- busy_o  output  1  high from START until STOP
- byte_cnt_o  output  CNT_W  bytes since the last (R)START, saturating

Behaviour:
- Reset (asynchronous, rst_ni = 0):
  - sync flops and filtered lines = 1; filter counters = 0; state = IDLE; bit_cnt = 0; shift register = 0.
  - All outputs 0, including byte_o, byte_cnt_o and busy_o.
  - Reset mid-frame discards the partial frame; no pulse is emitted on release.
- Sync: 2-flop synchronizer per line.
- Filter, per line:
  - counter increments while sync value != filtered value; clears when they are equal.
  - When the count reaches FILT_CYCLES, the filtered value flips and the counter clears.
  - Pin-to-filtered latency = 2 + FILT_CYCLES clocks. Pulses shorter than FILT_CYCLES clocks are rejected.
- Edges are taken from the filtered lines versus their previous-cycle values (scl_q, sda_q).
  - START condition: SDA falls while scl_q = 1 and SCL = 1.
  - STOP condition: SDA rises while scl_q = 1 and SCL = 1.
  - SDA change in the same cycle as an SCL change is never a START or STOP. On an SCL rise, the current filtered SDA is sampled.
- State machine (IDLE, ADDR, DATA):
  - IDLE: SCL edges ignored. START -> ADDR, start_o, busy_o = 1, bit_cnt = 0, byte_cnt_o = 0. STOP -> stop_o only.
  - ADDR/DATA, SCL rise with bit_cnt 0..7: shift SDA into the shift register LSB end, bit_cnt++.
  - ADDR/DATA, SCL rise with bit_cnt = 8: latch ninth bit, bit_cnt = 0.
    - Next cycle: byte_valid_o = 1, byte_o = shift register, ninth_o = sampled bit, addr_o = 1 in ADDR / 0 in DATA.
    - byte_cnt_o++ (holds at all-ones); ADDR -> DATA.
  - ADDR/DATA, START condition: rstart_o; -> ADDR; bit_cnt = 0; byte_cnt_o = 0.
  - ADDR/DATA, STOP condition: stop_o; -> IDLE; busy_o = 0.
  - frame_err_o pulses in the same cycle as rstart_o or stop_o when bit_cnt != 0; the partial byte is dropped.
- Output timing: event pulses are registered, asserting 1 clock after the filtered edge. byte_o, ninth_o and addr_o hold their value until the next byte_valid_o.
- enable_i = 0:
  - state forced to IDLE, bit_cnt = 0, busy_o = 0; all pulses suppressed.
  - Sync and filter keep running.
  - Re-enable mid-transaction: bytes are not decoded until the next START.
- Byte then STOP: a STOP following the 9th SCL fall is legal, so no frame_err_o.

Test Plan:
- Filter rejection: FILT_CYCLES = 2; SDA low glitch of 1 clock while SCL high -> no start_o. Glitch of 3 clocks -> start_o, then stop_o when SDA returns high.
- Private write: START, 0x5A<<1|0 with ACK 0, data 0xA5 with T-bit 1, STOP -> two byte_valid_o pulses:
  - byte_o = 0xB4, addr_o = 1, ninth_o = 0;
  - byte_o = 0xA5, addr_o = 0, ninth_o = 1;
  - then byte_cnt_o = 2, stop_o, busy_o falls.
- Repeated START: START, 0x7E<<1 ACK 0, Sr, 0x08<<1|1 -> rstart_o, no frame_err_o; second byte 0x11 has addr_o = 1; byte_cnt_o = 1 after it.
- Mid-frame abort: START, 4 data bits, STOP -> frame_err_o and stop_o in the same cycle, no byte_valid_o, busy_o = 0.
- Simultaneous edges: SCL and SDA toggle in the same clock -> no start_o or stop_o; the SCL rise samples the new SDA.
- Reset/enable: assert rst_ni mid-byte -> all outputs 0 immediately. Drop enable_i mid-byte, re-enable, send 0x3C without START -> no byte_valid_o until the next START.
